// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch port.
package imem_pkg;

    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;

    localparam logic [31:0] NOP_FAULT_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  fault;
    } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry response FIFO between the read stage and the fetch consumer.
// clear discards every entry on the next edge and has priority over push/pop.
module imem_rsp_fifo
    import imem_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clear,
    input  logic      push,
    input  imem_rsp_t push_data,
    input  logic      pop,
    output imem_rsp_t head,
    output logic      full,
    output logic      empty
);

    imem_rsp_t  slot_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign head  = slot_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: payload storage has no reset; the count qualifies it, so only control state is reset.
    always_ff @(posedge clk) begin
        if (do_push && !clear) slot_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/imem_fetch_port.sv
// Byte-addressed instruction memory with valid/ready fetch, registered read and response buffer.
// Define IMEM_LOAD_EN to add the ld_* byte-write loader port.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int    ADDR_W      = 32,
    parameter int    DEPTH_BYTES = 1024,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [1:0]        rsp_fault,
    input  logic              flush
`ifdef IMEM_LOAD_EN
    ,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data
`endif
);

    localparam int                IDX_W          = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(DEPTH_BYTES - 4);

    logic [7:0] mem [DEPTH_BYTES];

    logic [1:0] occ_q, occ_d;
    logic       rs_valid_q, rs_valid_d;
    imem_rsp_t  rs_rsp_q, rs_rsp_d;
    logic       accept, pop;
    logic [1:0] req_fault;
    imem_rsp_t  fifo_head;
    logic       fifo_full, fifo_empty;

`ifdef IMEM_LOAD_EN
    // Memory writes use the pre-edge array, so a same-cycle fetch sees the old byte.
    always_ff @(posedge clk) begin
        if (ld_we && (ld_addr < ADDR_W'(DEPTH_BYTES))) mem[ld_addr[IDX_W-1:0]] <= ld_data;
    end
`endif

    always_comb begin
        req_fault                 = 2'b00;
        req_fault[FAULT_MISALIGN] = (req_addr[1:0] != 2'b00);
        req_fault[FAULT_RANGE]    = (req_addr > LAST_WORD_ADDR);
    end

    // occ covers the read stage plus the FIFO, so the FIFO can never overflow.
    assign req_ready = (occ_q != 2'd2) && !flush;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready && !flush;

    always_comb begin
        occ_d      = occ_q;
        rs_valid_d = rs_valid_q;
        rs_rsp_d   = rs_rsp_q;
        if (flush) begin
            occ_d      = 2'd0;
            rs_valid_d = 1'b0;
        end else begin
            occ_d      = occ_q + {1'b0, accept} - {1'b0, pop};
            rs_valid_d = accept;
            if (accept) begin
                rs_rsp_d.fault = req_fault;
                rs_rsp_d.data  = NOP_FAULT_WORD;
                if (req_fault == 2'b00) begin
                    for (int b = 0; b < 4; b++) begin
                        rs_rsp_d.data[31-8*b -: 8] = mem[{req_addr[IDX_W-1:2], 2'(b)}];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            rs_valid_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            rs_valid_q <= rs_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        rs_rsp_q <= rs_rsp_d;
    end

    imem_rsp_fifo u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (rs_valid_q),
        .push_data (rs_rsp_q),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Outputs read as zero whenever no response is presented, including straight out of reset.
    assign rsp_data  = rsp_valid ? fifo_head.data  : NOP_FAULT_WORD;
    assign rsp_fault = rsp_valid ? fifo_head.fault : 2'b00;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port; builds with or without IMEM_LOAD_EN.
module tb_imem_fetch_port;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_data;
    logic [1:0]        rsp_fault;
    logic              flush = 1'b0;
`ifdef IMEM_LOAD_EN
    logic              ld_we = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [7:0]        ld_data = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    imem_fetch_port #(.ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH), .INIT_FILE("")) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_fault (rsp_fault),
        .flush     (flush)
`ifdef IMEM_LOAD_EN
        ,
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
`endif
    );

    always #5 clk = ~clk;

    // Per-iteration trace of one stream run; iteration c is sampled just before edge c+1.
    logic [ADDR_W-1:0] req_list [8];
    logic [31:0]       tr_data  [32];
    logic              tr_valid [32];
    logic              tr_rready[32];
    logic [31:0]       pop_data [8];
    logic [1:0]        pop_fault[8];
    int                pop_cyc  [8];
    int                acc_cyc  [8];
    int                n_pop, n_acc;

    task automatic preload_word(input logic [ADDR_W-1:0] a, input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
`ifdef IMEM_LOAD_EN
            @(negedge clk);
            ld_we   = 1'b1;
            ld_addr = a + ADDR_W'(b);
            ld_data = w[31-8*b -: 8];
            @(negedge clk);
            ld_we   = 1'b0;
`else
            dut.mem[int'(a) + b] = w[31-8*b -: 8];
`endif
        end
    endtask

    task automatic stream(input int n, input int rdy_from, input int ncyc);
        n_pop     = 0;
        n_acc     = 0;
        pop_data  = '{default: 'x};
        pop_fault = '{default: 'x};
        pop_cyc   = '{default: -1};
        acc_cyc   = '{default: -1};
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            req_valid = (n_acc < n);
            req_addr  = (n_acc < n) ? req_list[n_acc] : '0;
            rsp_ready = (c >= rdy_from);
            #1;
            tr_data[c]   = rsp_data;
            tr_valid[c]  = rsp_valid;
            tr_rready[c] = req_ready;
            if (rsp_valid && rsp_ready && n_pop < 8) begin
                pop_data[n_pop]  = rsp_data;
                pop_fault[n_pop] = rsp_fault;
                pop_cyc[n_pop]   = c;
                n_pop++;
            end
            if (req_valid && req_ready) begin
                acc_cyc[n_acc] = c;
                n_acc++;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        n_checks++; if (rsp_fault !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_fault: got %b want 00", rsp_fault); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        req_list[0] = 32'h0;
        stream(1, 0, 4);
        n_checks++; if (n_pop !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", n_pop); end
        n_checks++; if (tr_valid[1] !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", tr_valid[1]); end
        n_checks++; if (pop_cyc[0] !== 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", pop_cyc[0]); end
        n_checks++; if (pop_data[0] !== 32'h0011_2233) begin n_fail++; $display("FAIL single_data: got %h want 00112233", pop_data[0]); end
        n_checks++; if (pop_fault[0] !== 2'b00) begin n_fail++; $display("FAIL single_fault: got %b want 00", pop_fault[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3] = '{32'h0011_2233, 32'h4455_6677, 32'h8899_aabb};
        int          exp_p [3] = '{2, 3, 5};
        int          exp_a [3] = '{0, 1, 3};
        req_list[0] = 32'h0;
        req_list[1] = 32'h4;
        req_list[2] = 32'h8;
        stream(3, 0, 10);
        n_checks++; if (n_pop !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", n_pop); end
        n_checks++; if (tr_rready[2] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b want 0", tr_rready[2]); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (pop_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, pop_data[i], exp_d[i]); end
            n_checks++; if (pop_cyc[i] !== exp_p[i]) begin n_fail++; $display("FAIL b2b_rsp_cycle[%0d]: got %0d want %0d", i, pop_cyc[i], exp_p[i]); end
            n_checks++; if (acc_cyc[i] !== exp_a[i]) begin n_fail++; $display("FAIL b2b_acc_cycle[%0d]: got %0d want %0d", i, acc_cyc[i], exp_a[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [3] = '{32'h8899_aabb, 32'h0011_2233, 32'h4455_6677};
        int          exp_p [3] = '{4, 5, 7};
        req_list[0] = 32'h8;
        req_list[1] = 32'h0;
        req_list[2] = 32'h4;
        stream(3, 4, 12);
        n_checks++; if (n_pop !== 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", n_pop); end
        n_checks++; if (tr_rready[2] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_third: got %b want 0", tr_rready[2]); end
        n_checks++; if (tr_rready[4] !== 1'b0) begin n_fail++; $display("FAIL bp_ready_at_pop: got %b want 0", tr_rready[4]); end
        n_checks++; if (acc_cyc[2] !== 5) begin n_fail++; $display("FAIL bp_third_accept: got %0d want 5", acc_cyc[2]); end
        n_checks++; if (tr_valid[3] !== 1'b1 || tr_data[3] !== 32'h8899_aabb) begin n_fail++; $display("FAIL bp_hold: got %b/%h want 1/8899aabb", tr_valid[3], tr_data[3]); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (pop_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, pop_data[i], exp_d[i]); end
            n_checks++; if (pop_cyc[i] !== exp_p[i]) begin n_fail++; $display("FAIL bp_rsp_cycle[%0d]: got %0d want %0d", i, pop_cyc[i], exp_p[i]); end
        end
    endtask

    task automatic test_faults();
        logic [31:0] exp_d [5] = '{32'h0, 32'h0, 32'h0, 32'hdead_beef, 32'h0};
        logic [1:0]  exp_f [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b10};
        req_list[0] = 32'h0000_0002;
        req_list[1] = 32'(DEPTH - 2);
        req_list[2] = 32'(DEPTH);
        req_list[3] = 32'(DEPTH - 4);
        req_list[4] = 32'hffff_fffc;
        stream(5, 0, 24);
        n_checks++; if (n_pop !== 5) begin n_fail++; $display("FAIL fault_count: got %0d want 5", n_pop); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (pop_fault[i] !== exp_f[i]) begin n_fail++; $display("FAIL fault_bits[%0d]: got %b want %b", i, pop_fault[i], exp_f[i]); end
            n_checks++; if (pop_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL fault_data[%0d]: got %h want %h", i, pop_data[i], exp_d[i]); end
        end
    endtask

    task automatic test_flush();
        req_list[0] = 32'h0;
        req_list[1] = 32'h4;
        stream(2, 100, 4);
        req_valid = 1'b1;
        req_addr  = 32'h8;
        rsp_ready = 1'b1;
        flush     = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready_forced: got %b want 0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b want 1", rsp_valid); end
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_cleared: got %b want 0", rsp_valid); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %b want 1", req_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %b want 0", rsp_valid); end
    endtask

`ifdef IMEM_LOAD_EN
    task automatic test_load();
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h10;
        rsp_ready = 1'b1;
        ld_we     = 1'b1;
        ld_addr   = 32'h10;
        ld_data   = 8'hab;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        ld_we     = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hc0c1_c2c3) begin n_fail++; $display("FAIL load_old_word: got %b/%h want 1/c0c1c2c3", rsp_valid, rsp_data); end
        @(negedge clk);
        rsp_ready = 1'b0;
        ld_we     = 1'b1;
        ld_addr   = 32'(DEPTH);
        ld_data   = 8'h55;
        @(negedge clk);
        ld_we     = 1'b0;
        req_list[0] = 32'h10;
        req_list[1] = 32'h0;
        stream(2, 0, 10);
        n_checks++; if (n_pop !== 2) begin n_fail++; $display("FAIL load_count: got %0d want 2", n_pop); end
        n_checks++; if (pop_data[0] !== 32'habc1_c2c3) begin n_fail++; $display("FAIL load_new_word: got %h want abc1c2c3", pop_data[0]); end
        n_checks++; if (pop_data[1] !== 32'h0011_2233) begin n_fail++; $display("FAIL load_oob_dropped: got %h want 00112233", pop_data[1]); end
    endtask
`endif

    task automatic test_reset_mid_stream();
        req_list[0] = 32'h0;
        req_list[1] = 32'h4;
        stream(2, 100, 4);
        #1;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", rsp_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", rsp_valid); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
        n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h want 0", rsp_data); end
        n_checks++; if (rsp_fault !== 2'b00) begin n_fail++; $display("FAIL rst_mid_fault: got %b want 00", rsp_fault); end
        @(negedge clk);
        rst_n = 1'b1;
        req_list[0] = 32'h4;
        stream(1, 0, 4);
        n_checks++; if (n_pop !== 1 || pop_data[0] !== 32'h4455_6677) begin n_fail++; $display("FAIL rst_recover: got %0d/%h want 1/44556677", n_pop, pop_data[0]); end
    endtask

    initial begin
        preload_word(32'h0,  32'h0011_2233);
        preload_word(32'h4,  32'h4455_6677);
        preload_word(32'h8,  32'h8899_aabb);
        preload_word(32'h10, 32'hc0c1_c2c3);
        preload_word(32'(DEPTH - 4), 32'hdead_beef);
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_backpressure();
        test_faults();
        test_flush();
`ifdef IMEM_LOAD_EN
        test_load();
`endif
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
